// File: rtl/bus_fabric_mmio_pkg.sv
// bus_fabric_mmio_pkg: shared bus target encoding, MMIO offsets and TCTRL bit positions
package bus_fabric_mmio_pkg;
  typedef enum logic [1:0] {TGT_NONE, TGT_ROM, TGT_RAM, TGT_MMIO} tgt_e;
  localparam logic [4:0] OFF_GPIO_OUT = 5'h00;
  localparam logic [4:0] OFF_GPIO_IN  = 5'h04;
  localparam logic [4:0] OFF_TCOUNT   = 5'h08;
  localparam logic [4:0] OFF_TCMP     = 5'h0C;
  localparam logic [4:0] OFF_TCTRL    = 5'h10;
  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_FLAG = 1;
  localparam int TCTRL_AR   = 2;
endpackage

// File: rtl/bus_fabric_mmio_timer_gpio.sv
// mmio_timer_gpio: GPIO registers, input synchroniser and compare timer behind the MMIO window
module mmio_timer_gpio
  import bus_fabric_mmio_pkg::*;
#(
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic                  i_rd,
  input  logic [4:0]            i_off,
  input  logic [31:0]           i_wrdata,
  input  logic [GPIO_WIDTH-1:0] i_gpio_in,
  output logic [31:0]           o_rddata,
  output logic [GPIO_WIDTH-1:0] o_gpio_out,
  output logic                  o_timer_irq
);
  logic [GPIO_WIDTH-1:0] r_gpio_out, r_sync1, r_sync2;
  logic [31:0] r_count, r_cmp, r_rddata, w_reg;
  logic r_en, r_ar, r_flag, w_match, w_wr_ctrl;

  assign w_match     = r_en && (r_count == r_cmp);
  assign w_wr_ctrl   = i_wr && (i_off == OFF_TCTRL);
  assign o_rddata    = r_rddata;
  assign o_gpio_out  = r_gpio_out;
  assign o_timer_irq = r_flag;

  // register read mux; reserved offsets fall through to zero
  always_comb begin
    w_reg = i_off == OFF_GPIO_OUT ? 32'(r_gpio_out) :
            i_off == OFF_GPIO_IN  ? 32'(r_sync2) :
            i_off == OFF_TCOUNT   ? r_count :
            i_off == OFF_TCMP     ? r_cmp :
            i_off == OFF_TCTRL    ? {29'd0, r_ar, r_flag, r_en} : 32'd0;
  end

  // register writes, timer step (bus write beats increment, match set beats W1C) and synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_count    <= '0;
      r_cmp      <= '0;
      r_rddata   <= '0;
      r_en       <= 1'b0;
      r_ar       <= 1'b0;
      r_flag     <= 1'b0;
    end else begin
      r_sync1 <= i_gpio_in;
      r_sync2 <= r_sync1;
      if (i_rd) r_rddata <= w_reg;
      if (i_wr && i_off == OFF_GPIO_OUT) r_gpio_out <= i_wrdata[GPIO_WIDTH-1:0];
      if (i_wr && i_off == OFF_TCMP) r_cmp <= i_wrdata;
      if (i_wr && i_off == OFF_TCOUNT) r_count <= i_wrdata;
      else if (r_en) r_count <= (w_match && r_ar) ? 32'd0 : r_count + 32'd1;
      if (w_wr_ctrl) begin
        r_en <= i_wrdata[TCTRL_EN];
        r_ar <= i_wrdata[TCTRL_AR];
      end
      if (w_match) r_flag <= 1'b1;
      else if (w_wr_ctrl && i_wrdata[TCTRL_FLAG]) r_flag <= 1'b0;
    end
  end
endmodule

// File: rtl/bus_fabric_mmio.sv
// bus_fabric_mmio: decodes the core bus onto ROM, RAM and the MMIO block with one-cycle read data
module bus_fabric_mmio
  import bus_fabric_mmio_pkg::*;
#(
  parameter logic [31:0] ROM_BASE       = 32'h0040_0000,
  parameter logic [31:0] RAM_BASE       = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE      = 32'h1001_1000,
  parameter int          MEM_WORDS_LOG2 = 10,
  parameter int          GPIO_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               bus_addr,
  input  logic [31:0]               bus_wrdata,
  input  logic                      bus_wren,
  input  logic                      bus_rden,
  output logic [31:0]               bus_rddata,
  output logic                      bus_err,
  output logic [MEM_WORDS_LOG2-1:0] rom_addr,
  input  logic [31:0]               rom_rddata,
  output logic [MEM_WORDS_LOG2-1:0] ram_addr,
  output logic [31:0]               ram_wrdata,
  output logic                      ram_wren,
  input  logic [31:0]               ram_rddata,
  input  logic [GPIO_WIDTH-1:0]     gpio_in,
  output logic [GPIO_WIDTH-1:0]     gpio_out,
  output logic                      timer_irq
);
  localparam logic [31:0] MEM_BYTES = 32'd4 << MEM_WORDS_LOG2;
  logic [31:0] w_rom_rel, w_ram_rel, w_mmio_rel, w_mmio_rd;
  logic w_rom_hit, w_ram_hit, w_mmio_hit, w_hit, w_err;
  tgt_e w_sel, r_sel;
  logic r_err;

  // unsigned offset compare also rejects addresses below each base
  assign w_rom_rel  = bus_addr - ROM_BASE;
  assign w_ram_rel  = bus_addr - RAM_BASE;
  assign w_mmio_rel = bus_addr - MMIO_BASE;
  assign w_rom_hit  = w_rom_rel < MEM_BYTES;
  assign w_ram_hit  = w_ram_rel < MEM_BYTES;
  assign w_mmio_hit = w_mmio_rel < 32'h20;
  assign w_hit      = w_rom_hit || w_ram_hit || w_mmio_hit;
  assign rom_addr   = w_rom_rel[MEM_WORDS_LOG2+1:2];
  assign ram_addr   = w_ram_rel[MEM_WORDS_LOG2+1:2];
  assign ram_wrdata = bus_wrdata;
  assign ram_wren   = bus_wren && w_ram_hit;
  assign bus_err    = r_err;

  // a read collided with a write is served as NONE
  always_comb begin
    w_sel = (!bus_rden || bus_wren) ? TGT_NONE :
            w_rom_hit  ? TGT_ROM :
            w_ram_hit  ? TGT_RAM :
            w_mmio_hit ? TGT_MMIO : TGT_NONE;
    w_err = (bus_rden && w_sel == TGT_NONE) || (bus_wren && (w_rom_hit || !w_hit));
  end

  // select register holds the last target until the next read; error is a single pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= TGT_NONE;
      r_err <= 1'b0;
    end else begin
      if (bus_rden) r_sel <= w_sel;
      r_err <= w_err;
    end
  end

  // read data mux driven by the registered select
  always_comb begin
    bus_rddata = r_sel == TGT_ROM  ? rom_rddata :
                 r_sel == TGT_RAM  ? ram_rddata :
                 r_sel == TGT_MMIO ? w_mmio_rd : 32'd0;
  end

  mmio_timer_gpio #(.GPIO_WIDTH(GPIO_WIDTH)) u_mmio (
    .clk        (clk),
    .rst        (rst),
    .i_wr       (bus_wren && w_mmio_hit),
    .i_rd       (bus_rden && !bus_wren && w_mmio_hit),
    .i_off      ({w_mmio_rel[4:2], 2'b00}),
    .i_wrdata   (bus_wrdata),
    .i_gpio_in  (gpio_in),
    .o_rddata   (w_mmio_rd),
    .o_gpio_out (gpio_out),
    .o_timer_irq(timer_irq)
  );
endmodule

// File: tb/tb_bus_fabric_mmio.sv
// tb_bus_fabric_mmio: directed vectors with hand-computed expectations for the bus fabric
module tb_bus_fabric_mmio;
  localparam logic [31:0] ROM = 32'h0040_0000;
  localparam logic [31:0] RAM = 32'h1001_0000;
  localparam logic [31:0] MB  = 32'h1001_1000;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] bus_addr, bus_wrdata, bus_rddata, rom_rddata, ram_rddata, ram_wrdata;
  logic bus_wren, bus_rden, bus_err, ram_wren, timer_irq;
  logic [9:0] rom_addr, ram_addr;
  logic [7:0] gpio_in, gpio_out;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] d;
  logic e;

  always #5 clk = ~clk;

  bus_fabric_mmio dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
    .bus_wren(bus_wren), .bus_rden(bus_rden), .bus_rddata(bus_rddata), .bus_err(bus_err),
    .rom_addr(rom_addr), .rom_rddata(rom_rddata), .ram_addr(ram_addr),
    .ram_wrdata(ram_wrdata), .ram_wren(ram_wren), .ram_rddata(ram_rddata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    bus_addr = a; bus_wrdata = v; bus_wren = 1'b1;
    step();
    bus_wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic er);
    bus_addr = a; bus_rden = 1'b1;
    step();
    bus_rden = 1'b0;
    v = bus_rddata;
    er = bus_err;
  endtask

  initial begin
    rst = 1'b1; bus_addr = '0; bus_wrdata = '0; bus_wren = 1'b0; bus_rden = 1'b0;
    rom_rddata = '0; ram_rddata = '0; gpio_in = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_rddata", bus_rddata, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_gpio", gpio_out, 0);
    chk("rst_irq", timer_irq, 0);

    rom_rddata = 32'h1234_5678;
    bus_addr = 32'h0040_0008; #1;
    chk("rom_addr", rom_addr, 2);
    rd(32'h0040_0008, d, e);
    chk("rom_rd", d, 32'h1234_5678);
    chk("rom_err", e, 0);

    bus_addr = 32'h1001_0010; bus_wrdata = 32'hCAFE_F00D; bus_wren = 1'b1; #1;
    chk("ram_wren", ram_wren, 1);
    chk("ram_addr", ram_addr, 4);
    chk("ram_wrdata", ram_wrdata, 32'hCAFE_F00D);
    step(); bus_wren = 1'b0; #1;
    chk("ram_wren_off", ram_wren, 0);
    ram_rddata = 32'hCAFE_F00D;
    rd(32'h1001_0010, d, e);
    chk("ram_rd", d, 32'hCAFE_F00D);

    wr(MB + 32'h00, 32'h0000_00A5);
    chk("gpio_out", gpio_out, 8'hA5);
    rd(MB + 32'h00, d, e);
    chk("gpio_rd", d, 32'h0000_00A5);
    wr(MB + 32'h00, 32'h0001_2345);
    chk("gpio_mask", gpio_out, 8'h45);
    gpio_in = 8'h3C;
    rd(MB + 32'h04, d, e); chk("gin_c1", d, 0);
    rd(MB + 32'h04, d, e); chk("gin_c2", d, 0);
    rd(MB + 32'h04, d, e); chk("gin_c3", d, 32'h3C);
    wr(MB + 32'h04, 32'hFF);
    chk("gin_wr_err", bus_err, 0);
    rd(MB + 32'h04, d, e); chk("gin_wr_ign", d, 32'h3C);
    rd(MB + 32'h14, d, e);
    chk("resv_rd", d, 0);
    chk("resv_err", e, 0);

    wr(MB + 32'h0C, 32'd5);
    wr(MB + 32'h10, 32'h5);
    for (int i = 0; i < 7; i++) begin
      rd(MB + 32'h08, d, e);
      chk($sformatf("tcnt_ar%0d", i), d, (i == 6) ? 32'd0 : 32'(i));
      chk($sformatf("irq_ar%0d", i), timer_irq, (i >= 5) ? 32'd1 : 32'd0);
    end
    wr(MB + 32'h10, 32'h7);
    chk("w1c_clear", timer_irq, 0);
    step(); step(); step();
    wr(MB + 32'h10, 32'h7);
    chk("w1c_vs_set", timer_irq, 1);
    wr(MB + 32'h10, 32'h7);
    chk("w1c_clear2", timer_irq, 0);

    wr(MB + 32'h10, 32'h2);
    wr(MB + 32'h0C, 32'd3);
    wr(MB + 32'h08, 32'hFFFF_FFFF);
    wr(MB + 32'h10, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      rd(MB + 32'h08, d, e);
      chk($sformatf("tcnt_wrap%0d", k), d, (k == 1) ? 32'hFFFF_FFFF : 32'(k - 2));
      chk($sformatf("irq_wrap%0d", k), timer_irq, (k >= 5) ? 32'd1 : 32'd0);
    end
    wr(MB + 32'h10, 32'h1);
    chk("flag_keep", timer_irq, 1);
    rd(MB + 32'h10, d, e);
    chk("tctrl_rd", d, 32'h3);
    wr(MB + 32'h08, 32'd100);
    rd(MB + 32'h08, d, e);
    chk("tcnt_bus_wins", d, 32'd100);

    rd(32'h2000_0000, d, e);
    chk("unmap_rd", d, 0);
    chk("unmap_rd_err", e, 1);
    step();
    chk("err_pulse", bus_err, 0);
    wr(ROM, 32'hDEAD_BEEF);
    chk("rom_wr_err", bus_err, 1);
    wr(32'h2000_0000, 32'h1);
    chk("unmap_wr_err", bus_err, 1);
    bus_addr = RAM; bus_wrdata = 32'h55AA_55AA; bus_wren = 1'b1; bus_rden = 1'b1; #1;
    chk("both_ram_wren", ram_wren, 1);
    step(); bus_wren = 1'b0; bus_rden = 1'b0;
    chk("both_rd", bus_rddata, 0);
    chk("both_err", bus_err, 1);
    step();
    chk("both_err_pulse", bus_err, 0);

    rd(MB + 32'h08, d, e);
    bus_addr = 32'h2000_0000; bus_rden = 1'b1; rst = 1'b1;
    step();
    bus_rden = 1'b0; rst = 1'b0;
    chk("rst2_rddata", bus_rddata, 0);
    chk("rst2_err", bus_err, 0);
    chk("rst2_irq", timer_irq, 0);
    chk("rst2_gpio", gpio_out, 0);
    step();
    rd(MB + 32'h08, d, e); chk("rst2_tcnt", d, 0);
    rd(MB + 32'h10, d, e); chk("rst2_tctrl", d, 0);
    rd(MB + 32'h0C, d, e); chk("rst2_tcmp", d, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_fabric_mmio.md
Name: bus_fabric_mmio

Overview:
Downstream neighbour of the RV32I multi-cycle core. It consumes the core's single shared bus (bus_addr, bus_wrdata, bus_wren, bus_rden) and produces bus_rddata. It decodes each access to one of three targets: instruction ROM, data RAM, or an internal MMIO block. The MMIO block holds GPIO registers and a compare timer with an interrupt flag. All state is clocked on clk.

Parameters:
ROM_BASE, 32'h0040_0000, base byte address of instruction ROM
RAM_BASE, 32'h1001_0000, base byte address of data RAM
MMIO_BASE, 32'h1001_1000, base byte address of MMIO register block
MEM_WORDS_LOG2, 10, log2 of the word count of ROM and of RAM (1024 words = 4 KiB each)
GPIO_WIDTH, 8, width of gpio_out and gpio_in

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
bus_addr  in  32  byte address from core
bus_wrdata  in  32  write data from core
bus_wren  in  1  write strobe, one cycle per access
bus_rden  in  1  read strobe, one cycle per access
bus_rddata  out  32  read data, valid the cycle after bus_rden
bus_err  out  1  one-cycle pulse on unmapped or illegal access
rom_addr  out  MEM_WORDS_LOG2  word index to synchronous ROM
rom_rddata  in  32  ROM data, one cycle after rom_addr
ram_addr  out  MEM_WORDS_LOG2  word index to synchronous RAM
ram_wrdata  out  32  RAM write data
ram_wren  out  1  RAM write enable
ram_rddata  in  32  RAM data, one cycle after ram_addr
gpio_in  in  GPIO_WIDTH  asynchronous external inputs
gpio_out  out  GPIO_WIDTH  GPIO output register
timer_irq  out  1  level; equals the timer flag

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - bus_rddata = 0, bus_err = 0, gpio_out = 0, timer_irq = 0.
  - Timer count, compare and ctrl registers = 0.
  - Registered target select = NONE.
  - GPIO synchroniser flops = 0.
- Decode (combinational on bus_addr):
  - A region is hit when bus_addr is in [BASE, BASE + 4·2^MEM_WORDS_LOG2) for ROM and RAM, and [MMIO_BASE, MMIO_BASE + 0x20) for MMIO.
  - Word index = (bus_addr − BASE) >> 2. Address bits [1:0] are ignored.
- rom_addr and ram_addr are driven combinationally from bus_addr at all times.
- ram_wren = bus_wren && RAM hit. ram_wrdata = bus_wrdata.
- ROM is read-only. A write to ROM is dropped and pulses bus_err.
- Read latency is exactly 1 cycle:
  - On bus_rden in cycle N, the fabric registers the target select (ROM / RAM / MMIO / NONE).
  - For an MMIO read, the register value is captured in cycle N.
  - In cycle N+1, bus_rddata is muxed from the selected source.
  - NONE returns 0 and bus_err pulses in cycle N+1.
- Without a new bus_rden, the select is held, so bus_rddata keeps reflecting the last target.
- bus_wren and bus_rden asserted together:
  - The write is performed.
  - The read is treated as NONE (returns 0).
  - bus_err pulses in cycle N+1.
- Unmapped write: no state changes; bus_err pulses in cycle N+1.
- MMIO map (offset from MMIO_BASE):
  - 0x00 GPIO_OUT: RW, lower GPIO_WIDTH bits; upper bits read as 0.
  - 0x04 GPIO_IN: RO, via a 2-flop synchroniser, so 2-cycle input delay. Writes are ignored, with no error.
  - 0x08 TCOUNT: RW, 32-bit.
  - 0x0C TCMP: RW, 32-bit.
  - 0x10 TCTRL: bit0 EN, bit1 FLAG (read; write-1-to-clear), bit2 AUTORELOAD. Other bits read as 0.
  - 0x14 to 0x1C: reserved. Reads return 0 with no error; writes are ignored.
- Timer, per cycle while EN = 1:
  - If TCOUNT == TCMP: FLAG <= 1, and TCOUNT <= (AUTORELOAD ? 0 : TCOUNT + 1).
  - Otherwise TCOUNT <= TCOUNT + 1, wrapping 0xFFFF_FFFF → 0 with no flag.
  - EN = 0 freezes TCOUNT.
- Simultaneous timer events:
  - A bus write to TCOUNT in the same cycle as an increment: the bus write wins.
  - A match and a W1C of FLAG in the same cycle: the set wins, so FLAG stays 1.
  - Writing TCTRL with bit1 = 0 leaves FLAG unchanged.
- timer_irq = FLAG, registered with no extra delay.
- A reset asserted mid-access aborts the access. In the next cycle bus_rddata = 0 and bus_err = 0.

Decomposition:
- Shared package (be_pkg or a new bus_pkg) holds:
  - the bus target enum (TGT_NONE, TGT_ROM, TGT_RAM, TGT_MMIO);
  - the MMIO offset localparams;
  - the TCTRL bit-index constants.
- One natural sub-module: mmio_timer_gpio, containing the MMIO registers, the timer and the synchroniser. The fabric keeps decode, the select register and the rddata mux.

Test Plan:
1. Reset, then rden at 0x0040_0008 with rom_rddata = 0x1234_5678 → rom_addr = 2; bus_rddata = 0x1234_5678 one cycle later; bus_err = 0.
2. wren at 0x1001_0010 with data 0xCAFE_F00D, then rden at the same address → ram_wren = 1 for one cycle with ram_addr = 4; the readback returns ram_rddata.
3. Write TCMP = 5, then TCTRL = 0x5 (EN + AUTORELOAD) → TCOUNT runs 0..5 and then reads 0. timer_irq rises the cycle after the match. Write TCTRL = 0x7 → the flag clears unless a match occurs in the same cycle.
4. Write 0xA5 to GPIO_OUT, then read it back → gpio_out = 0xA5; readback = 0x0000_00A5. Set gpio_in = 0x3C → a GPIO_IN read returns 0x3C from the third cycle after the change.
5. rden at 0x2000_0000, wren to 0x0040_0000, and wren + rden together at the RAM base → each returns 0 on reads and pulses bus_err once. The ROM write is dropped; the combined access writes RAM.
6. Assert rst during a pending read and during a running timer → all outputs and registers return to 0 the next cycle.
